// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg -- shared definitions for the LCD serial receive path.
//   lcd_state_e         : receiver state (IDLE / RECV)
//   LCD_RS_INSTR/DATA   : meaning of the register-select line
//   LCD_TIMEOUT_CYCLES  : default idle-clk limit between bits of a byte
// ---------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } lcd_state_e;

  localparam logic LCD_RS_INSTR = 1'b0;
  localparam logic LCD_RS_DATA  = 1'b1;

  localparam int unsigned LCD_TIMEOUT_CYCLES = 100000;

endpackage

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2 -- two-flop synchronizer for signals asynchronous to clk.
//   clk, rst_n : system clock, async active-low reset
//   d_i        : asynchronous input
//   q_o        : synchronized output (two clk of delay)
// RST_VAL sets the value both stages take in reset, so a line that idles
// high does not produce a false edge when reset is released.
// ---------------------------------------------------------------------------
module sync2 #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: registers are written with <= so every flop samples the values
  // from before the clock edge; = here would collapse the two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/lcd_serial_rx.sv
// ---------------------------------------------------------------------------
// lcd_serial_rx -- receiver for a 3-wire (+RS) LCD serial bus.
//   clk, rst_n        : system clock, async active-low reset
//   csb, scl, si, rs  : asynchronous bus pins (chip select low, clock idles
//                       high, data MSB first, register select)
//   byte_data/byte_rs : received byte and the rs level at its last bit
//   byte_valid        : byte held until byte_ready=1
//   byte_ready        : consumer accepts the held byte
//   frame_err         : 1-clk pulse, partial byte discarded
//   overrun           : 1-clk pulse, new byte dropped (old one not taken)
//   busy              : receiver is inside a csb-low frame
// Build option: define LCD_SERIAL_RX_TIMEOUT_EN to abort a partial byte
// after more than TIMEOUT_CYCLES clk without an scl rising edge.
// ---------------------------------------------------------------------------
module lcd_serial_rx
  import lcd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = LCD_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       csb,
  input  logic       scl,
  input  logic       si,
  input  logic       rs,
  output logic [7:0] byte_data,
  output logic       byte_rs,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("lcd_serial_rx: TIMEOUT_CYCLES must be nonzero");
  end

  logic csb_s, scl_s, si_s, rs_s;

  sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_csb (.clk(clk), .rst_n(rst_n), .d_i(csb), .q_o(csb_s));
  sync2 #(.WIDTH(1), .RST_VAL(1'b1)) u_sync_scl (.clk(clk), .rst_n(rst_n), .d_i(scl), .q_o(scl_s));
  sync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_si  (.clk(clk), .rst_n(rst_n), .d_i(si),  .q_o(si_s));
  sync2 #(.WIDTH(1), .RST_VAL(1'b0)) u_sync_rs  (.clk(clk), .rst_n(rst_n), .d_i(rs),  .q_o(rs_s));

  lcd_state_e state_q;
  logic       scl_dly_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shreg_q;
  logic       done_q;      // byte completed last cycle, offer it now
  logic       last_rs_q;   // rs captured with the 8th bit
  logic [7:0] byte_data_q;
  logic       byte_rs_q;
  logic       byte_valid_q;
  logic       frame_err_q;
  logic       overrun_q;
  logic       scl_rise;

`ifdef LCD_SERIAL_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scl_dly_q <= 1'b1;
    else        scl_dly_q <= scl_s;
  end

  assign scl_rise = scl_s & ~scl_dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shreg_q      <= 8'h00;
      done_q       <= 1'b0;
      last_rs_q    <= LCD_RS_INSTR;
      byte_data_q  <= 8'h00;
      byte_rs_q    <= LCD_RS_INSTR;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef LCD_SERIAL_RX_TIMEOUT_EN
      idle_cnt_q   <= '0;
`endif
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;

      // Output holding register. shreg_q cannot change in the cycle after
      // completion: a new scl rise needs scl_s to fall and rise again first.
      if (done_q) begin
        if (byte_valid_q && !byte_ready) begin
          overrun_q <= 1'b1;
        end else begin
          byte_data_q  <= shreg_q;
          byte_rs_q    <= last_rs_q;
          byte_valid_q <= 1'b1;
        end
      end else if (byte_ready) begin
        byte_valid_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (!csb_s) state_q <= ST_RECV;
        end
        ST_RECV: begin
          // csb release wins over a coincident scl edge.
          if (csb_s) begin
            state_q <= ST_IDLE;
            if (bit_cnt_q != 3'd0) frame_err_q <= 1'b1;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 8'h00;
          end else if (scl_rise) begin
            shreg_q   <= {shreg_q[6:0], si_s};
            bit_cnt_q <= bit_cnt_q + 3'd1;  // wraps to 0 after the 8th bit
            if (bit_cnt_q == 3'd7) begin
              done_q    <= 1'b1;
              last_rs_q <= rs_s;
            end
          end
`ifdef LCD_SERIAL_RX_TIMEOUT_EN
          else if (bit_cnt_q != 3'd0 && idle_cnt_q == TO_W'(TIMEOUT_CYCLES)) begin
            frame_err_q <= 1'b1;
            bit_cnt_q   <= 3'd0;
            shreg_q     <= 8'h00;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase

`ifdef LCD_SERIAL_RX_TIMEOUT_EN
      // Counts clk since the last scl rise while a byte is partially in.
      if (state_q != ST_RECV || bit_cnt_q == 3'd0 || scl_rise)
        idle_cnt_q <= '0;
      else
        idle_cnt_q <= idle_cnt_q + TO_W'(1);
`endif
    end
  end

  assign byte_data  = byte_data_q;
  assign byte_rs    = byte_rs_q;
  assign byte_valid = byte_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lcd_serial_rx.sv
// ---------------------------------------------------------------------------
// tb_lcd_serial_rx -- scoreboard bench for lcd_serial_rx.
// Stimulus pushes expected bytes into exp_q; a monitor on the falling clock
// edge pops and compares on every valid/ready handshake and counts the
// frame_err / overrun pulses. Build with LCD_SERIAL_RX_TIMEOUT_EN to add the
// timeout scenario (DUT built with TIMEOUT_CYCLES = 50).
// ---------------------------------------------------------------------------
module tb_lcd_serial_rx;
  import lcd_pkg::*;

  localparam int PH = 20;  // clk per scl phase

  typedef struct packed {
    logic [7:0] data;
    logic       rs;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n, csb, scl, si, rs, byte_ready;
  logic [7:0] byte_data;
  logic       byte_rs, byte_valid, frame_err, overrun, busy;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  int   fe_cnt = 0;
  int   ov_cnt = 0;

  lcd_serial_rx #(.TIMEOUT_CYCLES(50)) dut (
    .clk(clk), .rst_n(rst_n), .csb(csb), .scl(scl), .si(si), .rs(rs),
    .byte_data(byte_data), .byte_rs(byte_rs), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .frame_err(frame_err), .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: away from the active edge, so valid/ready are settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (byte_valid && byte_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_byte", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_data", 32'(byte_data), 32'(e.data));
          check("sb_rs",   32'(byte_rs),   32'(e.rs));
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Falling phase with data, then rising edge; returns right at the rise.
  task automatic send_bit(input logic b);
    scl = 1'b0;
    si  = b;
    wait_cyc(PH);
    scl = 1'b1;
  endtask

  // First n bits of b, MSB first, each ending after its high phase.
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      send_bit(b[7-i]);
      wait_cyc(PH);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, fe0, ov0;
    logic [7:0] b;

    rst_n = 1'b0; csb = 1'b1; scl = 1'b1; si = 1'b0; rs = LCD_RS_INSTR;
    byte_ready = 1'b0;
    wait_cyc(3);
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_data",  32'(byte_data),  32'h00);
    check("rst_rs",    32'(byte_rs),    32'd0);
    check("rst_ferr",  32'(frame_err),  32'd0);
    check("rst_ovr",   32'(overrun),    32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    rst_n = 1'b1;
    wait_cyc(3);

    // 0x38 instruction byte, latency measured from the 8th rise at the pin.
    hs0 = hs_cnt; fe0 = fe_cnt;
    rs = LCD_RS_INSTR;
    exp_q.push_back('{data: 8'h38, rs: LCD_RS_INSTR});
    csb = 1'b0;
    wait_cyc(5);
    check("t1_busy", 32'(busy), 32'd1);
    b = 8'h38;
    send_bits(b, 7);
    send_bit(b[0]);
    wait_cyc(3);
    check("t1_valid_lat3", 32'(byte_valid), 32'd0);
    wait_cyc(1);
    check("t1_valid_lat4", 32'(byte_valid), 32'd1);
    check("t1_data", 32'(byte_data), 32'h38);
    check("t1_rs",   32'(byte_rs),   32'd0);
    byte_ready = 1'b1;
    wait_cyc(PH);
    csb = 1'b1;
    wait_cyc(5);
    check("t1_hs", 32'(hs_cnt - hs0), 32'd1);
    check("t1_idle_busy", 32'(busy), 32'd0);
    check("t1_ferr", 32'(fe_cnt - fe0), 32'd0);

    // Two data bytes in one frame, consumer always ready.
    hs0 = hs_cnt; fe0 = fe_cnt; ov0 = ov_cnt;
    rs = LCD_RS_DATA;
    exp_q.push_back('{data: 8'h41, rs: LCD_RS_DATA});
    exp_q.push_back('{data: 8'h42, rs: LCD_RS_DATA});
    csb = 1'b0;
    wait_cyc(5);
    send_bits(8'h41, 8);
    send_bits(8'h42, 8);
    csb = 1'b1;
    wait_cyc(5);
    check("t2_hs",   32'(hs_cnt - hs0), 32'd2);
    check("t2_ferr", 32'(fe_cnt - fe0), 32'd0);
    check("t2_ovr",  32'(ov_cnt - ov0), 32'd0);

    // Five bits then csb release: one frame_err, nothing delivered.
    hs0 = hs_cnt; fe0 = fe_cnt;
    rs = LCD_RS_INSTR;
    csb = 1'b0;
    wait_cyc(5);
    send_bits(8'hFF, 5);
    csb = 1'b1;
    wait_cyc(10);
    check("t3_ferr",  32'(fe_cnt - fe0), 32'd1);
    check("t3_hs",    32'(hs_cnt - hs0), 32'd0);
    check("t3_busy",  32'(busy),         32'd0);
    check("t3_valid", 32'(byte_valid),   32'd0);

    // Overrun: 0x01 held, 0x02 dropped, then 0x02 loaded on a ready cycle.
    ov0 = ov_cnt;
    byte_ready = 1'b0;
    exp_q.push_back('{data: 8'h01, rs: LCD_RS_INSTR});
    csb = 1'b0;
    wait_cyc(5);
    send_bits(8'h01, 8);
    check("t4_valid1", 32'(byte_valid), 32'd1);
    check("t4_data1",  32'(byte_data),  32'h01);
    send_bits(8'h02, 8);
    check("t4_hold_data", 32'(byte_data), 32'h01);
    check("t4_ovr",       32'(ov_cnt - ov0), 32'd1);
    exp_q.push_back('{data: 8'h02, rs: LCD_RS_INSTR});
    b = 8'h02;
    send_bits(b, 7);
    send_bit(b[0]);
    wait_cyc(3);
    byte_ready = 1'b1;  // ready during the completion cycle
    wait_cyc(1);
    check("t4_valid2", 32'(byte_valid), 32'd1);
    check("t4_data2",  32'(byte_data),  32'h02);
    wait_cyc(PH);
    csb = 1'b1;
    wait_cyc(5);
    check("t4_ovr_once", 32'(ov_cnt - ov0), 32'd1);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a byte, then a clean 0xA5.
    hs0 = hs_cnt; fe0 = fe_cnt;
    csb = 1'b0;
    wait_cyc(5);
    send_bits(8'hE0, 3);
    rst_n = 1'b0;
    wait_cyc(2);
    check("t5_rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    wait_cyc(5);
    exp_q.push_back('{data: 8'hA5, rs: LCD_RS_INSTR});
    send_bits(8'hA5, 8);
    csb = 1'b1;
    wait_cyc(5);
    check("t5_hs",   32'(hs_cnt - hs0), 32'd1);
    check("t5_ferr", 32'(fe_cnt - fe0), 32'd0);

`ifdef LCD_SERIAL_RX_TIMEOUT_EN
    // Stalled partial byte times out; the frame continues with 0x5A.
    hs0 = hs_cnt; fe0 = fe_cnt;
    csb = 1'b0;
    wait_cyc(5);
    send_bits(8'hC0, 3);
    wait_cyc(60);
    check("t6_ferr", 32'(fe_cnt - fe0), 32'd1);
    check("t6_busy", 32'(busy),         32'd1);
    exp_q.push_back('{data: 8'h5A, rs: LCD_RS_INSTR});
    send_bits(8'h5A, 8);
    csb = 1'b1;
    wait_cyc(5);
    check("t6_hs",       32'(hs_cnt - hs0), 32'd1);
    check("t6_ferr_end", 32'(fe_cnt - fe0), 32'd1);
`endif

    wait_cyc(10);
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
